// File: rtl/vram_frame_streamer.sv
// -----------------------------------------------------------------------------
// vram_frame_streamer
//
// Streams one stored frame out of VRAM as a valid/ready byte stream. On an
// accepted start the block picks the original or the composited image, walks
// its VRAM addresses in order and pushes every returned byte through a 4-entry
// FIFO to the downstream pixel port. Reads are throttled so that bytes already
// in the FIFO plus the single read in flight never exceed the FIFO depth, so
// the FIFO cannot overflow no matter how pix_ready behaves.
//
// Ports
//   clk           in   1   single clock, all state on the rising edge
//   reset         in   1   asynchronous reset, active low
//   start         in   1   stream one frame (only looked at while idle)
//   image_select  in   1   0 = original image, 1 = composited image
//   gpu_address   out  32  VRAM read address
//   vram_rd       out  1   VRAM read strobe, data returns one cycle later
//   vram_out      in   8   VRAM read data
//   pix_data      out  8   pixel byte (FIFO head)
//   pix_valid     out  1   pix_data valid (FIFO not empty)
//   pix_ready     in   1   downstream accepts the current beat
//   pix_last      out  1   current beat is the last one of the frame
//   busy          out  1   frame in progress
//   done          out  1   one-cycle pulse after the last beat transferred
// -----------------------------------------------------------------------------
module vram_frame_streamer #(
    parameter int ORIG_PIXELS = 160000,
    parameter int OUT_PIXELS  = 90000,
    parameter int ORIG_BASE   = 0,
    parameter int OUT_BASE    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        image_select,
    output logic [31:0] gpu_address,
    output logic        vram_rd,
    input  logic [7:0]  vram_out,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);

    localparam int MAX_PIXELS = (ORIG_PIXELS > OUT_PIXELS) ? ORIG_PIXELS : OUT_PIXELS;
    localparam int CNT_W      = $clog2(MAX_PIXELS + 1);
    localparam int FIFO_DEPTH = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam cnt_t        ORIG_N = cnt_t'(ORIG_PIXELS);
    localparam cnt_t        OUT_N  = cnt_t'(OUT_PIXELS);
    localparam logic [31:0] ORIG_A = 32'(ORIG_BASE);
    localparam logic [31:0] OUT_A  = 32'(OUT_BASE);

    state_t      state_q, state_d;
    cnt_t        n_q, n_d;            // pixels in the current frame
    cnt_t        issued_q, issued_d;  // reads issued so far
    cnt_t        beats_q, beats_d;    // beats transferred so far
    logic [31:0] addr_q, addr_d;

    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        rd_pend_q;           // a read was issued last cycle, its data is on vram_out now

    logic [3:0]  outstanding;
    logic        push;
    logic        pop;
    logic        last_beat;

    // Occupancy uses the registered count only; a pop in the same cycle is not
    // credited, which costs nothing in throughput (steady state is 1 + 1 < 4).
    assign outstanding = {1'b0, count_q} + {3'b000, rd_pend_q};
    assign vram_rd     = (state_q == ST_STREAM) && (issued_q != n_q)
                         && (outstanding < 4'(FIFO_DEPTH));

    assign push      = rd_pend_q;
    assign pix_valid = (count_q != 3'd0);
    assign pop       = pix_valid && pix_ready;
    assign last_beat = (beats_q == n_q - cnt_t'(1));

    assign pix_data    = fifo_q[rd_ptr_q];
    assign pix_last    = pix_valid && last_beat;
    assign gpu_address = addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        issued_d = issued_q;
        beats_d  = beats_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};

        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            beats_d  = beats_q + cnt_t'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_STREAM;
                    n_d      = image_select ? OUT_N : ORIG_N;
                    addr_d   = image_select ? OUT_A : ORIG_A;
                    issued_d = '0;
                    beats_d  = '0;
                end
            end
            ST_STREAM: begin
                if (vram_rd) begin
                    issued_d = issued_q + cnt_t'(1);
                    // The address stops on the last pixel rather than running
                    // one past the end of the image.
                    if (issued_q == n_q - cnt_t'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 32'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            issued_q  <= '0;
            beats_q   <= '0;
            addr_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            issued_q  <= issued_d;
            beats_q   <= beats_d;
            addr_q    <= addr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_pend_q <= vram_rd;
        end
    end

    // NOTE: this small storage array is reset on purpose: pix_data reads the
    // head entry directly and must show 0 while the block is held in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= vram_out;
        end
    end

endmodule

// File: tb/tb_vram_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_vram_frame_streamer
//
// Scoreboard bench: each frame start pushes the hand-derived beat sequence
// (address low byte, last flag) into a queue; a monitor on the falling edge
// pops and compares every transferred beat, checks stall stability, and
// collects timing and throttling statistics that the stimulus checks per frame.
// Edge numbering: cyc is the count of rising edges; a value sampled on the
// falling edge belongs to the cycle that follows rising edge cyc.
// -----------------------------------------------------------------------------
module tb_vram_frame_streamer;

    localparam int ORIG_N = 16;
    localparam int OUT_N  = 9;
    localparam int ORIG_B = 0;
    localparam int OUT_B  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        image_select;
    logic [31:0] gpu_address;
    logic        vram_rd;
    logic [7:0]  vram_out = 8'h00;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_last;
    logic        busy;
    logic        done;

    int n_cmp      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int rdy_mode   = 0;  // 0 = always ready, 1 = random, 2 = never ready
    int start_edge = 0;
    bit seen_flag  = 1'b0;

    logic [8:0] sb_q [$];

    // Monitor statistics, cleared when a start is about to be accepted.
    int          issued_total    = 0;
    int          beats_total     = 0;
    int          max_out         = 0;
    int          first_rd_cyc    = 0;
    int          first_beat_cyc  = 0;
    int          done_cyc        = 0;
    int          done_count      = 0;
    logic [31:0] first_rd_addr   = '0;
    logic [31:0] max_addr        = '0;
    bit          first_rd_seen   = 1'b0;
    bit          first_beat_seen = 1'b0;
    bit          prev_stall      = 1'b0;
    logic [9:0]  prev_vec        = '0;
    logic [8:0]  exp_beat;

    vram_frame_streamer #(
        .ORIG_PIXELS(ORIG_N),
        .OUT_PIXELS (OUT_N),
        .ORIG_BASE  (ORIG_B),
        .OUT_BASE   (OUT_B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .image_select(image_select),
        .gpu_address (gpu_address),
        .vram_rd     (vram_rd),
        .vram_out    (vram_out),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_last    (pix_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // VRAM: returns the low address byte one cycle after a read, junk otherwise.
    always @(posedge clk) vram_out <= vram_rd ? gpu_address[7:0] : 8'hA5;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1:       pix_ready = 1'($urandom_range(0, 1));
            2:       pix_ready = 1'b0;
            default: pix_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                issued_total    = 0;
                beats_total     = 0;
                max_out         = 0;
                done_count      = 0;
                max_addr        = '0;
                first_rd_seen   = 1'b0;
                first_beat_seen = 1'b0;
            end
            if (prev_stall) begin
                check("stall_hold", {22'd0, pix_valid, pix_last, pix_data}, {22'd0, prev_vec});
            end
            if (vram_rd) begin
                if (!first_rd_seen) begin
                    first_rd_seen = 1'b1;
                    first_rd_cyc  = cyc;
                    first_rd_addr = gpu_address;
                end
                if (issued_total - beats_total + 1 > max_out) begin
                    max_out = issued_total - beats_total + 1;
                end
                issued_total++;
            end
            if (busy && gpu_address > max_addr) begin
                max_addr = gpu_address;
            end
            if (pix_valid && !first_beat_seen) begin
                first_beat_seen = 1'b1;
                first_beat_cyc  = cyc;
            end
            if (pix_valid && pix_ready) begin
                beats_total++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_unexpected: got 0x%0h with no beat expected (edge %0d)", pix_data, cyc);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check("beat_data", 32'(pix_data), 32'(exp_beat[7:0]));
                    check("beat_last", 32'(pix_last), 32'(exp_beat[8]));
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_vec   = {pix_valid, pix_last, pix_data};
        end
    end

    task automatic push_frame(input logic sel);
        int n;
        int base;
        n    = sel ? OUT_N : ORIG_N;
        base = sel ? OUT_B : ORIG_B;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({(i == n - 1), 8'(base + i)});
        end
    endtask

    task automatic start_frame(input logic sel);
        @(posedge clk); #1;
        image_select = sel;
        start        = 1'b1;
        start_edge   = cyc + 1;
        push_frame(sel);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns one time unit after the rising edge that enters the DONE cycle.
    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic finish_frame(input logic sel, input logic timed);
        int n;
        int base;
        n    = sel ? OUT_N : ORIG_N;
        base = sel ? OUT_B : ORIG_B;
        @(posedge clk); #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("beat_count", beats_total, n);
        check("done_count", done_count, 1);
        check("sb_empty", sb_q.size(), 0);
        check("first_rd_addr", first_rd_addr, base);
        check("max_addr", max_addr, base + n - 1);
        check("outstanding_le4", 32'(max_out <= 4), 32'd1);
        if (timed) begin
            check("first_rd_edge", first_rd_cyc, start_edge);
            check("first_beat_edge", first_beat_cyc, start_edge + 2);
            check("done_edge", done_cyc, start_edge + n + 2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        image_select = 1'b0;

        // Reset state.
        #12;
        check("rst_gpu_address", gpu_address, 32'd0);
        check("rst_vram_rd", 32'(vram_rd), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #11 reset = 1'b1;

        // Original image, always ready: full-rate timing.
        rdy_mode = 0;
        start_frame(1'b0);
        wait_done(100);
        finish_frame(1'b0, 1'b1);

        // Composited image, always ready: address must stop at 108.
        start_frame(1'b1);
        wait_done(100);
        finish_frame(1'b1, 1'b1);

        // Random backpressure.
        rdy_mode = 1;
        start_frame(1'b0);
        wait_done(300);
        finish_frame(1'b0, 1'b0);

        // Downstream stalled for 20 cycles: only four reads may go out.
        rdy_mode = 2;
        start_frame(1'b0);
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("stall_issue_cap", issued_total, 4);
        check("stall_fifo_valid", 32'(pix_valid), 32'd1);
        rdy_mode = 0;
        wait_done(100);
        finish_frame(1'b0, 1'b0);

        // Start pulses and image_select toggles during a frame are ignored.
        rdy_mode = 1;
        start_frame(1'b0);
        seen_flag = 1'b0;
        for (int i = 0; i < 300 && !seen_flag; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen_flag = 1'b1;
            end else begin
                start        = (i % 3 == 0);
                image_select = ~image_select;
            end
        end
        start        = 1'b0;
        image_select = 1'b0;
        check("disturbed_done_seen", 32'(seen_flag), 32'd1);
        finish_frame(1'b0, 1'b0);

        // Start during DONE is ignored, start in the next IDLE cycle is taken.
        rdy_mode = 0;
        start_frame(1'b0);
        wait_done(100);
        start        = 1'b1;
        image_select = 1'b1;
        @(posedge clk); #1;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        start_edge = cyc + 1;
        push_frame(1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_done_taken", 32'(busy), 32'd1);
        wait_done(100);
        finish_frame(1'b1, 1'b1);

        // Reset in the middle of a frame, then a clean frame afterwards.
        start_frame(1'b0);
        for (int i = 0; i < 50 && beats_total < 5; i++) begin
            @(posedge clk); #1;
        end
        check("beat5_reached", beats_total, 5);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_gpu_address", gpu_address, 32'd0);
        check("mid_rst_vram_rd", 32'(vram_rd), 32'd0);
        check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("mid_rst_pix_last", 32'(pix_last), 32'd0);
        check("mid_rst_pix_data", 32'(pix_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_idle_valid", 32'(pix_valid), 32'd0);
        end
        start_frame(1'b0);
        wait_done(100);
        finish_frame(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_frame_streamer.md
VRAM_FRAME_STREAMER -- requirements
Module: vram_frame_streamer

Interface
REQ-001 Parameter ORIG_PIXELS, default 160000, pixel count of the original image (image_select=0); SHALL be ≥1.
REQ-002 Parameter OUT_PIXELS, default 90000, pixel count of the composited image (image_select=1); SHALL be ≥1.
REQ-003 Parameter ORIG_BASE, default 0, first VRAM address of the original image.
REQ-004 Parameter OUT_BASE, default 0, first VRAM address of the composited image.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 start  in  1  request to stream one frame; sampled only in IDLE.
REQ-008 image_select  in  1  frame choice, latched at accepted start: 0 = original, 1 = composited.
REQ-009 gpu_address  out  32  VRAM read address.
REQ-010 vram_rd  out  1  read strobe; VRAM returns data one cycle later.
REQ-011 vram_out  in  8  VRAM read data, valid exactly one cycle after vram_rd=1.
REQ-012 pix_data  out  8  streamed pixel byte.
REQ-013 pix_valid  out  1  pix_data valid.
REQ-014 pix_ready  in  1  downstream accepts; beat transfers when pix_valid&pix_ready.
REQ-015 pix_last  out  1  marks final pixel of the frame; valid only with pix_valid.
REQ-016 busy  out  1  frame in progress.
REQ-017 done  out  1  one-cycle pulse after the final beat transfers.

Function
REQ-018 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL latch image_select, load N (ORIG_PIXELS or OUT_PIXELS), load gpu_address with matching base, go STREAM next cycle.
REQ-020 STREAM: vram_rd SHALL assert only when issued<N and FIFO occupancy + reads in flight < 4; each issue increments gpu_address by 1 the following cycle.
REQ-021 STREAM SHALL go DRAIN in the cycle after the N-th read is issued.
REQ-022 Returned vram_out SHALL be written into a 4-entry FIFO in the cycle it is valid; the FIFO SHALL never overflow.
REQ-023 pix_valid SHALL equal FIFO non-empty; pix_data SHALL be the FIFO head, registered.
REQ-024 pix_data/pix_last SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-025 pix_last SHALL be 1 only on beat number N (counted from 1) of the frame.
REQ-026 DRAIN SHALL go DONE when the final beat transfers; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-027 busy SHALL be 1 in STREAM, DRAIN, DONE; 0 in IDLE.
REQ-028 start while busy=1 and image_select changes mid-frame SHALL be ignored.
REQ-029 Latency: start sampled at edge k -> vram_rd=1 with gpu_address=base in cycle k+1 -> first pix_valid in cycle k+3.
REQ-030 With pix_ready held 1, SHALL sustain one beat per cycle: final beat in cycle k+N+2, done in cycle k+N+3.
REQ-031 Beats SHALL emerge in address order base..base+N-1 with no loss or duplication under any pix_ready pattern.
REQ-032 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, gpu_address=0, vram_rd=0, pix_valid=0, pix_last=0, pix_data=0, busy=0, done=0, FIFO empty, counters 0.
REQ-034 reset mid-frame SHALL abort the frame; data returning in the cycle after reset release SHALL be discarded.
REQ-035 After reset release, the first start SHALL behave per REQ-029.

Verification (ORIG_PIXELS=16, OUT_PIXELS=9, ORIG_BASE=0, OUT_BASE=100; VRAM model returns addr[7:0])
REQ-036 start=1, image_select=0, pix_ready=1 -> 16 beats 0x00..0x0F on consecutive cycles starting at start+3, pix_last on 0x0F, done at start+19.
REQ-037 image_select=1, pix_ready=1 -> 9 beats 0x64..0x6C, pix_last on 0x6C, gpu_address never above 108.
REQ-038 image_select=0, pix_ready random 50% -> 16 beats in order, pix_data stable during stalls, vram_rd never makes occupancy+in-flight exceed 4.
REQ-039 pix_ready=0 for 20 cycles after start -> vram_rd stops after 4 issues; release -> all 16 beats correct.
REQ-040 start pulses and image_select toggles during a frame -> ignored; exactly one done; busy=0 after it.
REQ-041 reset=0 at beat 5 of a frame -> all outputs 0 asynchronously; new start after release -> full correct frame from base.
